elevator_scheduler: RTL



---
 rtl/elevator_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN elevator call scheduler; optional emergency stop under ELEVATOR_ESTOP_EN
module elevator_scheduler #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] switches,
  input  logic               in_out,
  input  logic               keypad,
`ifdef ELEVATOR_ESTOP_EN
  input  logic               estop,
`endif
  output logic [FLOORS-1:0]  call_mask,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic               arrive
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
`ifdef ELEVATOR_ESTOP_EN
    , STOP = 2'd3
`endif
  } state_t;

  state_t             state;
  logic [FLOORS-1:0]  cab;
  logic [FLOORS-1:0]  hall;
  logic [FLOORS-1:0]  pending;
  logic [FLOORS-1:0]  cur_oh;
  logic [FLOORS-1:0]  nxt_oh;
  logic [FLOORS-1:0]  req_vec;
  logic [FLOORS-1:0]  clr_vec;
  logic [FLOORS-1:0]  cab_nxt;
  logic [FLOORS-1:0]  hall_nxt;
  logic [FLOOR_W-1:0] nxt_floor;
  logic [MCW-1:0]     move_cnt;
  logic [DCW-1:0]     door_cnt;
  logic               above_cur;
  logic               below_cur;
  logic               above_nxt;
  logic               below_nxt;
  logic               at_cur;
  logic               at_nxt;
  logic               ahead_nxt;
  logic               behind_nxt;
  logic               go_up;
  logic               req_ok;
  logic               step;
  logic               door_hit;
  logic               door_done;

  assign pending   = cab | hall;
  assign call_mask = pending;

  // Floor decode and "calls above/below" searches around the current and next floor
  always_comb begin
    nxt_floor = dir_up ? (cur_floor + FLOOR_W'(1)) : (cur_floor - FLOOR_W'(1));
    cur_oh    = '0;
    nxt_oh    = '0;
    above_cur = 1'b0;
    below_cur = 1'b0;
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      cur_oh[i] = (FLOOR_W'(i) == cur_floor);
      nxt_oh[i] = (FLOOR_W'(i) == nxt_floor);
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) above_cur = 1'b1;
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) below_cur = 1'b1;
      if (pending[i] && (FLOOR_W'(i) > nxt_floor)) above_nxt = 1'b1;
      if (pending[i] && (FLOOR_W'(i) < nxt_floor)) below_nxt = 1'b1;
    end
    at_cur     = |(pending & cur_oh);
    at_nxt     = |(pending & nxt_oh);
    ahead_nxt  = dir_up ? above_nxt : below_nxt;
    behind_nxt = dir_up ? below_nxt : above_nxt;
    // Keep the current bias when calls lie on both sides
    go_up      = above_cur && (dir_up || !below_cur);
  end

  // Call capture merged with the clear of the floor being served (clear wins)
  always_comb begin
    req_ok  = keypad && (32'(switches) < 32'(FLOORS));
    req_vec = '0;
    for (int i = 0; i < FLOORS; i++) begin
      req_vec[i] = req_ok && (FLOOR_W'(i) == switches);
    end
    step      = (state == MOVE) && (move_cnt == MOVE_LAST);
    door_hit  = (state == DOOR) && req_ok && (switches == cur_floor);
    door_done = (state == DOOR) && !door_hit && (door_cnt == DOOR_LAST);
    clr_vec   = '0;
    if ((state == IDLE) && at_cur) clr_vec = cur_oh;
    if (step && at_nxt)            clr_vec = nxt_oh;
    if (state == DOOR)             clr_vec = cur_oh;
    cab_nxt  = (cab  | (in_out ? req_vec : '0)) & ~clr_vec;
    hall_nxt = (hall | (in_out ? '0 : req_vec)) & ~clr_vec;
`ifdef ELEVATOR_ESTOP_EN
    if (estop) begin
      cab_nxt  = '0;
      hall_nxt = '0;
    end
`endif
  end

  // Scheduler FSM with registered outputs and call masks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cab       <= '0;
      hall      <= '0;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      move_cnt  <= '0;
      door_cnt  <= '0;
    end
`ifdef ELEVATOR_ESTOP_EN
    else if (estop) begin
      state     <= STOP;
      cab       <= '0;
      hall      <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      move_cnt  <= '0;
      door_cnt  <= '0;
    end
`endif
    else begin
      cab    <= cab_nxt;
      hall   <= hall_nxt;
      arrive <= 1'b0;
      case (state)
        IDLE: begin
          if (at_cur) begin
            state     <= DOOR;
            door_open <= 1'b1;
            arrive    <= 1'b1;
            door_cnt  <= '0;
          end else if (go_up) begin
            dir_up   <= 1'b1;
            state    <= MOVE;
            moving   <= 1'b1;
            move_cnt <= '0;
          end else if (below_cur) begin
            dir_up   <= 1'b0;
            state    <= MOVE;
            moving   <= 1'b1;
            move_cnt <= '0;
          end
        end
        MOVE: begin
          if (step) begin
            cur_floor <= nxt_floor;
            move_cnt  <= '0;
            if (at_nxt) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              arrive    <= 1'b1;
              door_cnt  <= '0;
            end else if (!ahead_nxt) begin
              if (behind_nxt) begin
                dir_up <= ~dir_up;
              end else begin
                state  <= IDLE;
                moving <= 1'b0;
              end
            end
          end else begin
            move_cnt <= move_cnt + MCW'(1);
          end
        end
        DOOR: begin
          if (door_hit) begin
            door_cnt <= '0;
          end else if (door_done) begin
            door_open <= 1'b0;
            door_cnt  <= '0;
            if (go_up) begin
              dir_up   <= 1'b1;
              state    <= MOVE;
              moving   <= 1'b1;
              move_cnt <= '0;
            end else if (below_cur) begin
              dir_up   <= 1'b0;
              state    <= MOVE;
              moving   <= 1'b1;
              move_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            door_cnt <= door_cnt + DCW'(1);
          end
        end
`ifdef ELEVATOR_ESTOP_EN
        STOP: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
